// File: rtl/fetch_stage.sv
// Fetch stage: holds the PC, runs a single-outstanding imem request/ack handshake
// and drives the fetch-issue register. Optional perf counters: define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] next_pc_fetch_o,
  output logic [31:0] instr_fetch_o,
  output logic        iss_enable_o,
  output logic        iss_clr_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] npc_q;
  logic        valid_q;

  logic        req;
  logic        ack;
  logic        consume;

  // A new request goes out whenever the holding slot is empty or drains this cycle;
  // once raised, valid_q stays 0 until the ack, which keeps the request asserted.
  always_comb begin
    req = 1'b0;
    case (state_q)
      REQ, HOLD: req = ~valid_q | ~stall_i;
      DRAIN:     req = 1'b1;
      default:   req = 1'b0;
    endcase
    ack     = req & imem_ack_i;
    consume = valid_q & ~stall_i & ~redirect_i;
  end

  assign imem_req_o      = req;
  assign imem_addr_o     = (state_q == DRAIN) ? addr_q : pc_q;
  assign iss_enable_o    = ~consume;
  assign iss_clr_o       = reset_n & (redirect_i | (~valid_q & ~stall_i));
  assign next_pc_fetch_o = npc_q;
  assign instr_fetch_o   = instr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (redirect_i) begin
      valid_q <= 1'b0;
      pc_q    <= redirect_pc_i & ~32'd3;
      // An unacked request must finish on the old address; its data is dropped in DRAIN.
      if (req && !imem_ack_i) begin
        state_q <= DRAIN;
        if (state_q != DRAIN) addr_q <= pc_q;
      end else begin
        state_q <= REQ;
      end
    end else begin
      case (state_q)
        IDLE:  state_q <= REQ;
        DRAIN: if (imem_ack_i) state_q <= REQ;
        default: begin
          if (ack) begin
            instr_q <= imem_rdata_i;
            npc_q   <= pc_q + 32'd4;
            pc_q    <= pc_q + 32'd4;
            valid_q <= 1'b1;
            state_q <= stall_i ? HOLD : REQ;
          end else if (consume) begin
            valid_q <= 1'b0;
            state_q <= REQ;
          end else begin
            state_q <= valid_q ? HOLD : REQ;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (consume) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (iss_clr_o && !redirect_i) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign fetch_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a latency-controlled imem, random stalls and
// redirects, and a transaction-level reference model of the fetch/issue contract.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] next_pc_fetch_o;
  logic [31:0] instr_fetch_o;
  logic        iss_enable_o;
  logic        iss_clr_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_rdata_i    (imem_rdata_i),
    .next_pc_fetch_o (next_pc_fetch_o),
    .instr_fetch_o   (instr_fetch_o),
    .iss_enable_o    (iss_enable_o),
    .iss_clr_o       (iss_clr_o),
    .fetch_cnt_o     (fetch_cnt_o),
    .bubble_cnt_o    (bubble_cnt_o)
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h2008_0005;
  endfunction

  // Reference model: holding slot, fetch PC, and the one in-flight request.
  bit          m_first;
  bit          m_valid;
  logic [31:0] m_instr, m_npc, m_pc;
  bit          m_out, m_doomed;
  logic [31:0] m_out_addr;
  logic [31:0] m_fc, m_bc;

  // Memory and stimulus knobs
  int mem_wait, mem_lat, lat_fix, p_stall, p_redir;

  function automatic int pick_lat();
    return (lat_fix >= 0) ? lat_fix : int'($urandom_range(3));
  endfunction

  task automatic cycle(input bit force_r, input logic [31:0] ftgt);
    bit          exp_req, ack_now, m_consume, exp_clr;
    logic [31:0] exp_addr;
    int unsigned r;
    @(negedge clk);
    stall_i    = ($urandom_range(99) < p_stall) && !force_r;
    redirect_i = force_r || ($urandom_range(99) < p_redir);
    r = $urandom_range(9);
    redirect_pc_i = force_r ? ftgt : (r == 0) ? 32'hFFFF_FFFE : (r == 1) ? 32'h0000_0103 : $urandom;

    exp_req   = !m_first && (m_out || !m_valid || !stall_i);
    exp_addr  = m_out ? m_out_addr : m_pc;
    m_consume = m_valid && !stall_i && !redirect_i;
    exp_clr   = redirect_i || (!m_valid && !stall_i);

    ack_now      = exp_req ? (mem_wait >= mem_lat) : ($urandom_range(3) == 0);
    imem_ack_i   = ack_now;
    imem_rdata_i = ack_now ? mem_word(exp_addr) : $urandom;
    #1;
    check("req", imem_req_o, exp_req);
    if (exp_req) check("addr", imem_addr_o, exp_addr);
    check("iss_enable", iss_enable_o, !m_consume);
    check("iss_clr", iss_clr_o, exp_clr);
    check("next_pc", next_pc_fetch_o, m_npc);
    check("instr", instr_fetch_o, m_instr);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt_o, m_fc);
    check("bubble_cnt", bubble_cnt_o, m_bc);
`else
    check("fetch_cnt", fetch_cnt_o, 32'd0);
    check("bubble_cnt", bubble_cnt_o, 32'd0);
`endif

    if (m_consume) m_fc = m_fc + 1;
    if (exp_clr && !redirect_i) m_bc = m_bc + 1;
    if (m_consume) m_valid = 0;
    if (exp_req && ack_now && !redirect_i && !(m_out && m_doomed)) begin
      m_instr = mem_word(exp_addr);
      m_npc   = exp_addr + 32'd4;
      m_pc    = exp_addr + 32'd4;
      m_valid = 1;
    end
    if (exp_req && !ack_now) begin
      if (!m_out) begin
        m_out_addr = exp_addr;
        m_doomed   = 0;
      end
      m_out = 1;
      mem_wait++;
    end else if (exp_req) begin
      m_out    = 0;
      m_doomed = 0;
      mem_wait = 0;
      mem_lat  = pick_lat();
    end
    if (redirect_i) begin
      if (m_out) m_doomed = 1;
      m_valid = 0;
      m_pc    = redirect_pc_i & ~32'd3;
    end
    m_first = 0;
  endtask

  task automatic run_phase(input int n, input int lat, input int ps, input int pr);
    lat_fix = lat;
    p_stall = ps;
    p_redir = pr;
    if (!m_out) mem_lat = pick_lat();
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    m_first = 1; m_valid = 0; m_instr = '0; m_npc = '0; m_pc = '0;
    m_out = 0; m_doomed = 0; m_out_addr = '0; m_fc = '0; m_bc = '0;
    mem_wait = 0; lat_fix = 0; mem_lat = 0; p_stall = 0; p_redir = 0;
    #12;
    check("rst_req", imem_req_o, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0000_0000);
    check("rst_next_pc", next_pc_fetch_o, 32'd0);
    check("rst_instr", instr_fetch_o, 32'd0);
    check("rst_iss_enable", iss_enable_o, 32'd1);
    check("rst_iss_clr", iss_clr_o, 32'd0);
    check("rst_fetch_cnt", fetch_cnt_o, 32'd0);
    check("rst_bubble_cnt", bubble_cnt_o, 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    run_phase(40, 0, 0, 0);      // zero-wait streaming
    run_phase(40, 2, 0, 0);      // 3-cycle memory
    run_phase(80, 0, 35, 0);     // stalls with held instructions
    run_phase(60, 2, 20, 12);    // redirects with requests in flight
    lat_fix = 0; p_stall = 0; p_redir = 0;
    cycle(1'b1, 32'hFFFF_FFFC);  // wrap of the PC and next_pc
    run_phase(10, 0, 0, 0);
    run_phase(3000, -1, 25, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
